// File: rtl/fetch_thread_sched_if.sv
// Fetch scheduler bus: per-thread enables, miss/fill/replay events and the
// fetch valid/ready handshake between the scheduler and the front end.
interface fetch_thread_sched_if #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2
);
  logic [NTHREADS-1:0] thread_en;
  logic                fetch_ready;
  logic                fetch_valid;
  logic [TID_W-1:0]    fetch_thread;
  logic                miss;
  logic [TID_W-1:0]    miss_thread;
  logic                fill_done;
  logic [TID_W-1:0]    fill_thread;
  logic                replay;
  logic [TID_W-1:0]    replay_thread;
  logic [NTHREADS-1:0] thread_ready;

  modport master (
    input  thread_en, fetch_ready, miss, miss_thread, fill_done, fill_thread,
           replay, replay_thread,
    output fetch_valid, fetch_thread, thread_ready
  );

  modport slave (
    output thread_en, fetch_ready, miss, miss_thread, fill_done, fill_thread,
           replay, replay_thread,
    input  fetch_valid, fetch_thread, thread_ready
  );
endinterface

// File: rtl/fetch_thread_sched.sv
// Per-cycle fetch thread selector: per-thread HALTED/READY/WAIT_MISS/BLOCKED
// tracking with round-robin grant among READY threads.
module fetch_thread_sched #(
  parameter int unsigned NTHREADS      = 4,
  parameter int unsigned TID_W         = 2,
  parameter int unsigned REPLAY_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_thread_sched_if.master bus
);

  typedef enum logic [1:0] {HALTED, READY, WAIT_MISS, BLOCKED} state_t;

  state_t              state_q [NTHREADS];
  state_t              state_d [NTHREADS];
  logic [3:0]          cnt_q   [NTHREADS];
  logic [3:0]          cnt_d   [NTHREADS];
  logic [TID_W-1:0]    ptr_q;
  logic [TID_W-1:0]    ptr_d;
  logic [TID_W-1:0]    grant;
  logic                any_ready;
  logic [NTHREADS-1:0] ready;

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NTHREADS; i++)
      ready[i] = (state_q[i] == READY);
  end

  // Search starts at ptr; TID_W-bit addition wraps mod NTHREADS.
  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    for (int unsigned k = 0; k < NTHREADS; k++) begin
      if (!any_ready && ready[ptr_q + TID_W'(k)]) begin
        any_ready = 1'b1;
        grant     = ptr_q + TID_W'(k);
      end
    end
  end

  assign bus.fetch_valid  = any_ready;
  assign bus.fetch_thread = grant;
  assign bus.thread_ready = ready;

  always_comb begin
    ptr_d = ptr_q;
    if (any_ready && bus.fetch_ready)
      ptr_d = grant + TID_W'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NTHREADS; i++) begin
      logic miss_i, fill_i, replay_i;
      miss_i     = bus.miss      && (bus.miss_thread   == TID_W'(i));
      fill_i     = bus.fill_done && (bus.fill_thread   == TID_W'(i));
      replay_i   = bus.replay    && (bus.replay_thread == TID_W'(i));
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!bus.thread_en[i]) begin
        state_d[i] = HALTED;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          HALTED: state_d[i] = READY;
          READY: begin
            if (miss_i) begin
              state_d[i] = WAIT_MISS;
            end else if (replay_i) begin
              state_d[i] = BLOCKED;
              cnt_d[i]   = 4'(REPLAY_CYCLES);
            end
          end
          WAIT_MISS: begin
            if (!miss_i && fill_i)
              state_d[i] = READY;
          end
          BLOCKED: begin
            if (miss_i) begin
              state_d[i] = WAIT_MISS;
              cnt_d[i]   = '0;
            end else if (replay_i) begin
              cnt_d[i] = 4'(REPLAY_CYCLES);
            end else if (cnt_q[i] <= 4'd1) begin
              state_d[i] = READY;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end
          end
          default: state_d[i] = HALTED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < NTHREADS; i++) begin
        state_q[i] <= HALTED;
        cnt_q[i]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned i = 0; i < NTHREADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_thread_sched.sv
// Directed vector bench for fetch_thread_sched: each vector drives one cycle of
// inputs and lists the outputs expected during that cycle.
module tb_fetch_thread_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_thread_sched_if #(.NTHREADS(4), .TID_W(2)) bus ();

  fetch_thread_sched #(.NTHREADS(4), .TID_W(2), .REPLAY_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic       frdy;
    int         miss_t;
    int         fill_t;
    int         rep_t;
    logic       ev;
    int         eth;
    logic [3:0] erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] en, input logic frdy, input int miss_t,
                     input int fill_t, input int rep_t, input logic ev,
                     input int eth, input logic [3:0] erdy);
    vec_t v;
    v.en = en; v.frdy = frdy; v.miss_t = miss_t; v.fill_t = fill_t;
    v.rep_t = rep_t; v.ev = ev; v.eth = eth; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic frdy, input int miss_t,
                       input int fill_t, input int rep_t);
    bus.thread_en     = en;
    bus.fetch_ready   = frdy;
    bus.miss          = (miss_t >= 0);
    bus.miss_thread   = 2'(miss_t < 0 ? 0 : miss_t);
    bus.fill_done     = (fill_t >= 0);
    bus.fill_thread   = 2'(fill_t < 0 ? 0 : fill_t);
    bus.replay        = (rep_t >= 0);
    bus.replay_thread = 2'(rep_t < 0 ? 0 : rep_t);
  endtask

  task automatic check_out(input string tag, input int idx, input logic ev,
                           input int eth, input logic [3:0] erdy);
    check({tag, "_valid"}, idx, 32'(bus.fetch_valid), 32'(ev));
    check({tag, "_thread"}, idx, 32'(bus.fetch_thread), 32'(eth));
    check({tag, "_ready"}, idx, 32'(bus.thread_ready), 32'(erdy));
  endtask

  initial begin
    // Columns: en, fetch_ready, miss, fill, replay (-1 = none), valid, thread, ready
    add(4'hF, 1, -1, -1, -1, 0, 0, 4'b0000);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 2, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 3, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1111);
    add(4'h5, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'h5, 1, -1, -1, -1, 1, 2, 4'b0101);
    add(4'h5, 1, -1, -1, -1, 1, 0, 4'b0101);
    add(4'h5, 1, -1, -1, -1, 1, 2, 4'b0101);
    add(4'h5, 1, -1, -1, -1, 1, 0, 4'b0101);
    add(4'hF, 1, -1, -1, -1, 1, 2, 4'b0101);
    add(4'hF, 1,  1, -1, -1, 1, 3, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1101);
    add(4'hF, 1, -1, -1, -1, 1, 2, 4'b1101);
    add(4'hF, 1, -1,  1, -1, 1, 3, 4'b1101);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'hF, 1,  2, -1, -1, 1, 2, 4'b1111);
    add(4'hF, 1, -1,  2, -1, 1, 3, 4'b1011);
    add(4'hF, 1, -1, -1,  2, 1, 0, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 1, 4'b1011);
    add(4'hF, 1, -1, -1, -1, 1, 3, 4'b1011);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1011);
    add(4'hF, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 2, 4'b1111);
    for (int k = 0; k < 5; k++) add(4'hF, 0, -1, -1, -1, 1, 3, 4'b1111);
    add(4'hF, 1, -1, -1, -1, 1, 3, 4'b1111);
    add(4'hF, 1,  1,  1, -1, 1, 0, 4'b1111);
    add(4'hF, 1,  0, -1, -1, 1, 2, 4'b1101);
    add(4'hF, 1, -1, -1,  0, 1, 3, 4'b1100);
    add(4'hF, 1, -1,  0, -1, 1, 2, 4'b1100);
    add(4'hF, 1, -1,  1, -1, 1, 3, 4'b1101);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1111);
    add(4'hE, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'hE, 1,  0, -1, -1, 1, 2, 4'b1110);
    add(4'hF, 1, -1, -1, -1, 1, 3, 4'b1110);
    add(4'hF, 1, -1, -1,  1, 1, 0, 4'b1111);
    add(4'hF, 1,  1, -1, -1, 1, 2, 4'b1101);
    add(4'hF, 1, -1,  1, -1, 1, 3, 4'b1101);
    add(4'hF, 1, -1, -1, -1, 1, 0, 4'b1111);
    add(4'h0, 1, -1, -1, -1, 1, 1, 4'b1111);
    add(4'h0, 1, -1, -1, -1, 0, 0, 4'b0000);
    add(4'hF, 1, -1, -1, -1, 0, 0, 4'b0000);
    add(4'hF, 1, -1, -1, -1, 1, 2, 4'b1111);

    drive(4'h0, 1'b0, -1, -1, -1);
    #3;
    check_out("reset", 0, 0, 0, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].frdy, vecs[i].miss_t, vecs[i].fill_t, vecs[i].rep_t);
      #1;
      check_out("vec", i, vecs[i].ev, vecs[i].eth, vecs[i].erdy);
      @(negedge clk);
    end

    // Async reset pulse mid-cycle, away from any clock edge
    drive(4'hF, 1'b1, -1, -1, -1);
    #2 rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("post_rst", 0, 0, 0, 4'b0000);
    @(negedge clk);
    drive(4'hF, 1'b1, -1, -1, 0);
    #1;
    check_out("post_rst", 1, 1, 0, 4'b1111);

    // Replay reload while BLOCKED: thread 0 blocked r2..r6, ready at r7
    for (int r = 2; r <= 7; r++) begin
      @(negedge clk);
      drive(4'hF, 1'b1, -1, -1, (r == 3) ? 0 : -1);
      #1;
      check("reload_ready0", r, 32'(bus.thread_ready[0]), (r == 7) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
